// File: rtl/led_cube_scan_scheduler.sv
// Refresh scheduler for an 8x8x8 LED cube: loads eight row latches per layer from
// the frame buffer, then lights the layer with brightness-scaled PWM.
module led_cube_scan_scheduler #(
   parameter int LAYER_TIME   = 2048,
   parameter int LATCH_PULSE  = 2,
   parameter int BLANK_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] brightness,
   input  logic       swap_req,
   output logic       fb_rd_en,
   output logic [5:0] fb_rd_addr,
   input  logic [7:0] fb_rd_data,
   output logic       buf_sel,
   output logic [7:0] Layers_out,
   output logic [7:0] Latches_out,
   output logic [7:0] Data_out,
   output logic       frame_done,
   output logic       swap_done,
   output logic       busy
);

   localparam int CW = $clog2(LAYER_TIME + 1);

   localparam logic [CW-1:0] SHOW_LAST  = CW'(LAYER_TIME - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_PULSE - 1);
   localparam logic [CW-1:0] PWM_STEP   = CW'(LAYER_TIME / 16);

   typedef enum logic [2:0] {
      IDLE,
      BLANK,
      LOAD_RD,
      LOAD_SETUP,
      LOAD_LATCH,
      LOAD_HOLD,
      SHOW
   } state_t;

   state_t        state;
   logic [2:0]    layer;
   logic [2:0]    row;
   logic [CW-1:0] cnt;
   logic [CW-1:0] on_time;
   logic          swap_pending;

   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] on_entry;
   logic [7:0]    layer_oh;
   logic [7:0]    row_oh;

   assign cnt_inc  = cnt + CW'(1);
   assign on_entry = CW'(brightness) * PWM_STEP;
   assign layer_oh = 8'd1 << layer;
   assign row_oh   = 8'd1 << row;

   // Every output is a register loaded on the transition into the state that
   // owns it, so the pins never see decode glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         layer        <= '0;
         row          <= '0;
         cnt          <= '0;
         on_time      <= '0;
         swap_pending <= 1'b0;
         buf_sel      <= 1'b0;
         fb_rd_en     <= 1'b0;
         fb_rd_addr   <= '0;
         Layers_out   <= '0;
         Latches_out  <= '0;
         Data_out     <= '0;
         frame_done   <= 1'b0;
         swap_done    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         swap_done  <= 1'b0;
         fb_rd_en   <= 1'b0;
         fb_rd_addr <= '0;
         if (swap_req) swap_pending <= 1'b1;

         if (!enable) begin
            state       <= IDLE;
            layer       <= '0;
            row         <= '0;
            cnt         <= '0;
            Layers_out  <= '0;
            Latches_out <= '0;
            Data_out    <= '0;
            busy        <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state <= BLANK;
                  layer <= '0;
                  row   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end

               BLANK: begin
                  if (cnt == BLANK_LAST) begin
                     state      <= LOAD_RD;
                     row        <= '0;
                     cnt        <= '0;
                     fb_rd_en   <= 1'b1;
                     fb_rd_addr <= {layer, 3'd0};
                  end else begin
                     cnt <= cnt_inc;
                  end
               end

               LOAD_RD: state <= LOAD_SETUP;

               LOAD_SETUP: begin
                  state       <= LOAD_LATCH;
                  Data_out    <= fb_rd_data;
                  Latches_out <= row_oh;
                  cnt         <= '0;
               end

               LOAD_LATCH: begin
                  if (cnt == LATCH_LAST) begin
                     state       <= LOAD_HOLD;
                     Latches_out <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end

               LOAD_HOLD: begin
                  if (row == 3'd7) begin
                     // Brightness is captured once here so mid-slot changes wait a slot.
                     state      <= SHOW;
                     cnt        <= '0;
                     on_time    <= on_entry;
                     Layers_out <= (on_entry != '0) ? layer_oh : 8'd0;
                  end else begin
                     state      <= LOAD_RD;
                     row        <= row + 3'd1;
                     fb_rd_en   <= 1'b1;
                     fb_rd_addr <= {layer, row + 3'd1};
                  end
               end

               SHOW: begin
                  if (cnt == SHOW_LAST) begin
                     state      <= BLANK;
                     cnt        <= '0;
                     layer      <= layer + 3'd1;
                     Layers_out <= '0;
                     if (layer == 3'd7) begin
                        frame_done <= 1'b1;
                        if (swap_pending || swap_req) begin
                           buf_sel      <= ~buf_sel;
                           swap_done    <= 1'b1;
                           swap_pending <= 1'b0;
                        end
                     end
                  end else begin
                     cnt        <= cnt_inc;
                     Layers_out <= (cnt_inc < on_time) ? layer_oh : 8'd0;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/led_cube_scan_scheduler.md
Name: led_cube_scan_scheduler

Overview:
- Sequences the physical 8x8x8 cube refresh: one layer at a time, reads 8 row bytes from the frame buffer, shifts each onto Data_out and strobes the matching row latch, then enables the layer with brightness-scaled PWM.
- Sits between the frame buffer, which the animation, stream and message sources fill, and the Layers/Latches/Data pins.
- Owns the double-buffer swap so that frames change only at a frame boundary.

Parameters:
- LAYER_TIME, 2048: cycles per layer display slot; must be a multiple of 16.
- LATCH_PULSE, 2: cycles a row latch strobe is held high (≥1).
- BLANK_CYCLES, 4: layers-off guard cycles before loading each layer (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  scan run/stop
- brightness  in  4  PWM level; 0 = dark, 15 = 15/16 duty
- swap_req  in  1  single-cycle pulse requesting a buffer swap at the next frame boundary
- fb_rd_en  out  1  frame buffer read strobe
- fb_rd_addr  out  6  {layer[2:0], row[2:0]}
- fb_rd_data  in  8  read data, valid the cycle after fb_rd_en
- buf_sel  out  1  frame buffer bank being displayed
- Layers_out  out  8  one-hot layer enable, active high
- Latches_out  out  8  one-hot row latch strobe, active high
- Data_out  out  8  row data to latch inputs
- frame_done  out  1  1-cycle pulse after layer 7 slot completes
- swap_done  out  1  1-cycle pulse when buf_sel toggles
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset: state IDLE, layer=0, row=0, swap_pending=0, buf_sel=0. All other outputs are 0. All outputs are registered.
- IDLE: all outputs 0. When enable=1, go to BLANK with layer=0.
- BLANK: Layers_out=0 for BLANK_CYCLES cycles, then LOAD_RD with row=0.
- Row load sequence, per row r:
  - LOAD_RD (1 cycle): fb_rd_en=1, fb_rd_addr={layer,r}.
  - LOAD_SETUP (1 cycle): Data_out <= fb_rd_data at the end of this cycle.
  - LOAD_LATCH (LATCH_PULSE cycles): Latches_out=1<<r; Data_out stable.
  - LOAD_HOLD (1 cycle): Latches_out=0; Data_out held.
  - After HOLD: if r<7, go to LOAD_RD with r+1; else go to SHOW.
  - Row cost is 3+LATCH_PULSE cycles; 40 cycles per layer at defaults.
- SHOW: brightness is sampled on entry: on_time = brightness*(LAYER_TIME/16), 0..1920 at defaults. Counter runs for LAYER_TIME cycles. Layers_out=1<<layer while count<on_time, else 0. Latches_out=0.
- End of SHOW:
  - If layer<7: layer+1, go to BLANK.
  - If layer=7: layer wraps to 0, frame_done pulses, go to BLANK.
- Slot period is BLANK_CYCLES + 8*(3+LATCH_PULSE) + LAYER_TIME = 2092 cycles at defaults. Frame = 8 slots = 16736 cycles.
- Swap handling:
  - swap_req sets swap_pending.
  - In the frame_done cycle, if swap_pending=1 or swap_req=1: buf_sel toggles, swap_done pulses in the same cycle, swap_pending clears.
  - Multiple requests within one frame collapse into one swap.
  - A swap_req arriving in the cycle after frame_done waits for the next frame.
- Layers_out and Latches_out are never both non-zero in the same cycle. Layers_out is 0 throughout BLANK and LOAD.
- Changing brightness mid-SHOW has no effect until the next SHOW entry.
- enable=0 in any state: go to IDLE next cycle.
  - All outputs are zeroed. Layer and row reset to 0.
  - swap_pending and buf_sel are retained. No frame_done pulse.
- Re-enabling always restarts at layer 0, BLANK.
- rst mid-operation overrides everything, including a same-cycle swap or frame_done; reset values apply next cycle.

Test Plan:
- Reset, then enable=1, brightness=15, fb holds byte {layer,row} at each address:
  - First latch pulse is Latches_out=0x01 with Data_out=0x00, starting cycle 1+4+2 after enable.
  - Row 7 of layer 0 latches Data_out=0x07.
  - Layers_out=0x01 for exactly 1920 cycles, then 0 for 128 cycles.
- brightness=0: Layers_out stays 0 for the whole frame, while the latch sequence continues normally.
- brightness=8: on_time=1024 per slot.
  - Change brightness to 15 mid-SHOW; the current layer still shows 1024 cycles, the next layer 1920.
- swap_req pulsed mid-frame, twice: exactly one buf_sel toggle, coincident with frame_done and swap_done, at cycle 16736 of the frame.
  - swap_req in the frame_done cycle also swaps.
- Drop enable during LOAD_LATCH of layer 3:
  - Next cycle all outputs are 0 and busy=0.
  - Re-enable restarts at layer 0; buf_sel is unchanged.
- Assert rst during SHOW of layer 7 with swap_pending=1: no frame_done or swap_done pulse; buf_sel=0 and all outputs 0 next cycle.
- Check throughout all runs that Layers_out and Latches_out are never both non-zero.
